// File: rtl/seq_11_gen.sv
// -----------------------------------------------------------------------------
// seq_11_gen: serial pattern transmitter for an "11" Mealy sequence detector.
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per clock. While shifting, it counts the overlapping "11" pairs that a
// detector with persistent state would see. That count, including a pair that
// spans two back-to-back words, is reported per word on hit_cnt, together with
// a one-cycle done pulse.
//
// Build option: define SEQ_GEN_LSB_FIRST_EN to transmit LSB first (shift right).
// By default the word is transmitted MSB first (shift left).
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   in_valid  in   in_data is valid
//   in_data   in   word to transmit (WIDTH bits)
//   in_ready  out  a word can be accepted this cycle
//   out       out  serial bit, 0 when not shifting
//   out_valid out  out carries a payload bit
//   busy      out  transmitter is in the SHIFT state
//   done      out  one-cycle pulse in the cycle after the last bit of a word
//   hit_cnt   out  "11" hits of the most recently completed word (CNT_W bits)
// -----------------------------------------------------------------------------
module seq_11_gen #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt
);

    typedef enum logic [0:0] {StIdle, StShift} state_t;

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               prev_q;
    logic [CNT_W-1:0]   run_q;
    logic [CNT_W-1:0]   hit_q;
    logic               done_q;

    logic               shifting;
    logic               last_bit;
    logic               accept;
    logic               tx_bit;
    logic               hit_now;
    logic [WIDTH-1:0]   shreg_next;

`ifdef SEQ_GEN_LSB_FIRST_EN
    assign tx_bit     = shreg_q[0];
    assign shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
`else
    assign tx_bit     = shreg_q[WIDTH-1];
    assign shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = StShift;
        end else if (last_bit) begin
            state_d = StIdle;
        end
    end

    // Output logic
    always_comb begin
        shifting  = (state_q == StShift);
        last_bit  = shifting && (cnt_q == LastBit);
        out       = shifting ? tx_bit : 1'b0;
        out_valid = shifting;
        busy      = shifting;
        // Ready while idle, and in the last-bit cycle so words can run back-to-back.
        in_ready  = !shifting || last_bit;
        accept    = in_valid && in_ready;
        // prev_q is the previous cycle's out, so it is 0 after any idle cycle.
        hit_now   = out && prev_q;
        done      = done_q;
        hit_cnt   = hit_q;
    end

    // Datapath: shift register, bit counter, hit accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            run_q   <= '0;
            hit_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            prev_q <= out;
            done_q <= last_bit;
            // The last bit's own hit still belongs to the finishing word.
            if (last_bit) begin
                hit_q <= run_q + CNT_W'(hit_now);
            end
            if (accept) begin
                shreg_q <= in_data;
                cnt_q   <= '0;
                run_q   <= '0;
            end else if (last_bit) begin
                shreg_q <= '0;
                cnt_q   <= '0;
                run_q   <= '0;
            end else if (shifting) begin
                shreg_q <= shreg_next;
                cnt_q   <= cnt_q + CNT_W'(1);
                run_q   <= run_q + CNT_W'(hit_now);
            end
        end
    end

endmodule

// File: tb/tb_seq_11_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_11_gen: directed, scoreboard-based bench for seq_11_gen (WIDTH=8).
// Each accepted word pushes its expected serial bits and hit count; a monitor
// on the falling edge pops and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_seq_11_gen;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] hit_cnt;

    int tests = 0;
    int fails = 0;

    bit bq[$];
    bit lq[$];
    int cq[$];
    bit last_prev = 1'b0;
    int exp_hit   = 0;
    bit last_tx   = 1'b0;
    logic rst_s;

    seq_11_gen #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done),
        .hit_cnt  (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rst_s <= rst;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Push the expected bit stream and hit count of a word in transmit order.
    task automatic push_word(input logic [7:0] w, input bit prev);
        bit p;
        bit b;
        int hits;
        p    = prev;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef SEQ_GEN_LSB_FIRST_EN
            b = w[i];
`else
            b = w[7-i];
`endif
            if (b && p) hits++;
            p = b;
            bq.push_back(b);
            lq.push_back(i == 7);
        end
        cq.push_back(hits);
        last_tx = b;
    endtask

    // Monitor: compare DUT outputs with the scoreboard every cycle.
    always @(negedge clk) begin
        bit exp_done;
        if (rst_s === 1'b1) begin
            chk("rst_out", {7'd0, out}, 8'd0);
            chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
            chk("rst_busy", {7'd0, busy}, 8'd0);
            chk("rst_done", {7'd0, done}, 8'd0);
            chk("rst_hit_cnt", 8'(hit_cnt), 8'd0);
            bq.delete();
            lq.delete();
            cq.delete();
            last_prev = 1'b0;
            exp_hit   = 0;
        end else begin
            exp_done = last_prev;
            if (exp_done) begin
                if (cq.size() != 0) exp_hit = cq.pop_front();
            end
            chk("done", {7'd0, done}, {7'd0, exp_done});
            chk("hit_cnt", 8'(hit_cnt), 8'(exp_hit));
            if (bq.size() != 0) begin
                chk("out_valid", {7'd0, out_valid}, 8'd1);
                chk("busy", {7'd0, busy}, 8'd1);
                chk("out_bit", {7'd0, out}, {7'd0, bq.pop_front()});
                last_prev = lq.pop_front();
            end else begin
                chk("idle_out_valid", {7'd0, out_valid}, 8'd0);
                chk("idle_busy", {7'd0, busy}, 8'd0);
                chk("idle_out", {7'd0, out}, 8'd0);
                last_prev = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ready_is(input string tag, input bit exp);
        @(negedge clk);
        chk(tag, {7'd0, in_ready}, {7'd0, exp});
    endtask

    // Accept edge: the caller has checked in_ready=1 in the current cycle.
    task automatic accept(input logic [7:0] w, input bit prev);
        tick();
        push_word(w, prev);
    endtask

    task automatic not_ready(input int n);
        for (int i = 0; i < n; i++) begin
            ready_is("in_ready_mid", 1'b0);
            tick();
        end
    endtask

    // Bits 0..6 are not ready; ends at the falling edge of the last-bit cycle.
    task automatic mid_word();
        not_ready(7);
        ready_is("in_ready_last", 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Single word after idle: 0110_1110
        in_valid = 1'b1;
        in_data  = 8'b0110_1110;
        ready_is("in_ready_idle", 1'b1);
        accept(in_data, 1'b0);
        in_valid = 1'b0;
        mid_word();
        idle(4);

        // All ones from idle
        in_valid = 1'b1;
        in_data  = 8'hFF;
        ready_is("in_ready_idle", 1'b1);
        accept(in_data, 1'b0);
        in_valid = 1'b0;
        mid_word();
        idle(4);

        // Back-to-back 01 then 80 with in_valid held; boundary hit goes to word 2
        in_valid = 1'b1;
        in_data  = 8'h01;
        ready_is("in_ready_idle", 1'b1);
        accept(in_data, 1'b0);
        in_data = 8'h80;
        mid_word();
        accept(in_data, last_tx);
        in_valid = 1'b0;
        mid_word();
        idle(4);

        // in_valid raised during bit 3 is held off until the last-bit cycle
        in_valid = 1'b1;
        in_data  = 8'h0F;
        ready_is("in_ready_idle", 1'b1);
        accept(in_data, 1'b0);
        in_valid = 1'b0;
        not_ready(3);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        not_ready(4);
        ready_is("in_ready_last", 1'b1);
        accept(in_data, last_tx);
        in_valid = 1'b0;
        mid_word();
        idle(4);

        // Reset during bit 4 of FF: word discarded, no done, hit_cnt back to 0
        in_valid = 1'b1;
        in_data  = 8'hFF;
        ready_is("in_ready_idle", 1'b1);
        accept(in_data, 1'b0);
        in_valid = 1'b0;
        not_ready(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready_is("in_ready_after_rst", 1'b1);
        idle(12);

        // 0000_0011: bit order depends on the build
        in_valid = 1'b1;
        in_data  = 8'b0000_0011;
        ready_is("in_ready_idle", 1'b1);
        accept(in_data, 1'b0);
        in_valid = 1'b0;
        mid_word();
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
